wb_port_arbiter: RTL and testbench

Shares the single register-file write port between two producers: the ALU/link channel and the load-return channel from data memory.
- Grants one producer per cycle.
- Registers the winning operands and drives the write-back mux select, destination register and write enable.
- Sits between EX/MEM and the register file, in front of the write-back mux.
- Load priority is the default; an anti-starvation counter guarantees ALU progress.

---
 rtl/wb_port_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: grants the register-file write port to the ALU/link or load-return channel.
// Optional statistics counters are enabled with `define WB_ARB_STATS_EN.
//
// state    | meaning
// PRI_LOAD | load channel wins conflicts; ALU refusals are counted
// PRI_ALU  | ALU channel wins for one grant after MAX_WAIT refusals
module wb_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_is_link,
  input  logic [XLEN-1:0] alu_pc,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic [1:0]      wb_sel,
  output logic [XLEN-1:0] wb_alu_result,
  output logic [XLEN-1:0] wb_read_data,
  output logic [XLEN-1:0] wb_pc,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            starve_flag
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]     conflict_cnt,
  output logic [15:0]     starve_cnt
`endif
);

  localparam logic [0:0] PRI_LOAD   = 1'b0;
  localparam logic [0:0] PRI_ALU    = 1'b1;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [0:0] state, state_next;
  logic [3:0] wait_cnt, wait_next;
  logic       alu_xfer, ld_xfer, forced;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (rst_n) begin
      if (state == PRI_LOAD) begin
        if (ld_valid)       ld_ready  = 1'b1;
        else if (alu_valid) alu_ready = 1'b1;
      end else begin
        if (alu_valid)      alu_ready = 1'b1;
        else if (ld_valid)  ld_ready  = 1'b1;
      end
    end
  end

  assign alu_xfer = alu_valid && alu_ready;
  assign ld_xfer  = ld_valid && ld_ready;
  assign forced   = alu_xfer && (state == PRI_ALU) && ld_valid;

  always_comb begin
    wait_next = wait_cnt;
    if (alu_xfer)
      wait_next = 4'd0;
    else if (alu_valid && (wait_cnt != MAX_WAIT_C))
      wait_next = wait_cnt + 4'd1;
  end

  // Switching on the next count lets the forced grant land right after the last refusal.
  always_comb begin
    state_next = state;
    case (state)
      PRI_LOAD: if (wait_next == MAX_WAIT_C) state_next = PRI_ALU;
      PRI_ALU:  if (alu_xfer || !alu_valid) state_next = PRI_LOAD;
      default:  state_next = PRI_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PRI_LOAD;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_sel        <= 2'b00;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc         <= '0;
      wb_rd         <= 5'd0;
      wb_we         <= 1'b0;
      starve_flag   <= 1'b0;
    end else begin
      wb_we       <= 1'b0;
      starve_flag <= 1'b0;
      if (alu_xfer) begin
        wb_sel        <= alu_is_link ? 2'b10 : 2'b00;
        wb_alu_result <= alu_result;
        wb_pc         <= alu_pc;
        wb_rd         <= alu_rd;
        wb_we         <= |alu_rd;
        starve_flag   <= forced;
      end else if (ld_xfer) begin
        wb_sel       <= 2'b01;
        wb_read_data <= ld_data;
        wb_rd        <= ld_rd;
        wb_we        <= |ld_rd;
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 32'd0;
      starve_cnt   <= 16'd0;
    end else begin
      if (alu_valid && ld_valid)
        conflict_cnt <= conflict_cnt + 32'd1;
      if (forced && (starve_cnt != 16'hFFFF))
        starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, hand sequences and randomized traffic
// compared against a grant/refusal-count reference model.
module tb_wb_port_arbiter;
  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0, alu_is_link = 1'b0, ld_valid = 1'b0;
  logic [4:0]      alu_rd = '0, ld_rd = '0;
  logic [XLEN-1:0] alu_result = '0, alu_pc = '0, ld_data = '0;
  logic            alu_ready, ld_ready, wb_we, starve_flag;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] wb_alu_result, wb_read_data, wb_pc;
  logic [4:0]      wb_rd;
`ifdef WB_ARB_STATS_EN
  logic [31:0]     conflict_cnt;
  logic [15:0]     starve_cnt;
`endif

  wb_port_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_result(alu_result), .alu_is_link(alu_is_link), .alu_pc(alu_pc),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_sel(wb_sel), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_we(wb_we), .starve_flag(starve_flag)
`ifdef WB_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .starve_cnt(starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: who wins, how many consecutive refusals the ALU has suffered.
  bit              m_alu_first;
  int              m_refused;
  int              streak;
  logic [1:0]      e_sel;
  logic [31:0]     e_alu, e_rdat, e_pc;
  logic [4:0]      e_rd;
  logic            e_we, e_starve;
  bit              g_alu, g_ld;
  logic            s_ar, s_lr;

  task automatic model_reset();
    m_alu_first = 0; m_refused = 0; streak = 0;
    e_sel = 2'b00; e_alu = '0; e_rdat = '0; e_pc = '0; e_rd = '0;
    e_we = 0; e_starve = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".wb_we"}, 32'(wb_we), 32'(e_we));
    chk({tag, ".wb_sel"}, 32'(wb_sel), 32'(e_sel));
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(e_rd));
    chk({tag, ".wb_alu_result"}, wb_alu_result, e_alu);
    chk({tag, ".wb_read_data"}, wb_read_data, e_rdat);
    chk({tag, ".wb_pc"}, wb_pc, e_pc);
    chk({tag, ".starve_flag"}, 32'(starve_flag), 32'(e_starve));
  endtask

  // Called at a negedge: drive, check readies, predict, clock, check registered outputs.
  task automatic step(input string tag, input logic av, input logic [4:0] ard,
                      input logic [31:0] ares, input logic alink, input logic [31:0] apc,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    alu_valid = av; alu_rd = ard; alu_result = ares; alu_is_link = alink; alu_pc = apc;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    #1;
    s_ar = alu_ready; s_lr = ld_ready;
    g_ld  = lv && !(m_alu_first && av);
    g_alu = av && !g_ld;
    chk({tag, ".alu_ready"}, 32'(s_ar), 32'(g_alu));
    chk({tag, ".ld_ready"}, 32'(s_lr), 32'(g_ld));
    if (av && !s_ar) streak++; else streak = 0;
    chk({tag, ".refusal_bound"}, 32'(streak <= MAX_WAIT), 32'd1);
    e_we = 0; e_starve = 0;
    if (g_alu) begin
      e_starve = m_alu_first && lv;
      m_refused = 0;
      e_sel = alink ? 2'b10 : 2'b00; e_alu = ares; e_pc = apc; e_rd = ard; e_we = (ard != 0);
    end else begin
      if (av) m_refused = (m_refused + 1 > MAX_WAIT) ? MAX_WAIT : m_refused + 1;
      if (g_ld) begin
        e_sel = 2'b01; e_rdat = ldat; e_rd = lrd; e_we = (lrd != 0);
      end
    end
    m_alu_first = m_alu_first ? 0 : (m_refused == MAX_WAIT);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic logic [31:0] sel_data();
    case (wb_sel)
      2'b00:   return wb_alu_result;
      2'b01:   return wb_read_data;
      default: return wb_pc;
    endcase
  endfunction

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ares; logic alink; logic [31:0] apc;
    logic lv; logic [4:0] lrd; logic [31:0] ldat;
    logic e_ar; logic e_lr; logic e_we; logic [1:0] e_sel; logic [4:0] e_rd; logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[7];

  logic        p_av, p_alink, p_lv;
  logic [4:0]  p_ard, p_lrd;
  logic [31:0] p_ares, p_apc, p_ldat;
  logic [9:0]  grants;

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 32'h0,   1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 2'b00, 5'd5, 32'h1234};
    vecs[1] = '{1'b1, 5'd1, 32'hAAAA, 1'b1, 32'h104, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 2'b10, 5'd1, 32'h104};
    vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b0, 32'h0,   1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b1, 1'b0, 2'b01, 5'd0, 32'hDEAD};
    vecs[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 32'h0,   1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 2'b01, 5'd0, 32'hDEAD};
    vecs[4] = '{1'b0, 5'd0, 32'h0,    1'b0, 32'h0,   1'b1, 5'd7, 32'h55,   1'b0, 1'b1, 1'b1, 2'b01, 5'd7, 32'h55};
    vecs[5] = '{1'b1, 5'd3, 32'h77,   1'b0, 32'h0,   1'b1, 5'd8, 32'h66,   1'b0, 1'b1, 1'b1, 2'b01, 5'd8, 32'h66};
    vecs[6] = '{1'b1, 5'd4, 32'h99,   1'b0, 32'h200, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b1, 2'b00, 5'd4, 32'h99};

    // Reset held with both producers requesting.
    model_reset();
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h1234;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.alu_ready", 32'(alu_ready), 32'd0);
    chk("reset.ld_ready", 32'(ld_ready), 32'd0);
    check_outputs("reset");
    rst_n = 1'b1;
    step("first_grant", 1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 1'b1, 5'd2, 32'h11);
    chk("first_grant.is_load", 32'(s_lr), 32'd1);

    for (int i = 0; i < 7; i++) begin
      step($sformatf("vec%0d", i), vecs[i].av, vecs[i].ard, vecs[i].ares, vecs[i].alink,
           vecs[i].apc, vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
      chk($sformatf("vec%0d.tbl_alu_ready", i), 32'(s_ar), 32'(vecs[i].e_ar));
      chk($sformatf("vec%0d.tbl_ld_ready", i), 32'(s_lr), 32'(vecs[i].e_lr));
      chk($sformatf("vec%0d.tbl_we", i), 32'(wb_we), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d.tbl_sel", i), 32'(wb_sel), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d.tbl_rd", i), 32'(wb_rd), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d.tbl_data", i), sel_data(), vecs[i].e_dat);
    end

    // Continuous conflict: four loads, one forced ALU grant, loads resume.
    grants = '0;
    p_ard = 5'd10; p_ares = 32'hA0; p_lrd = 5'd20; p_ldat = 32'hB0;
    for (int i = 0; i < 10; i++) begin
      step($sformatf("starve%0d", i), 1'b1, p_ard, p_ares, 1'b0, 32'h0, 1'b1, p_lrd, p_ldat);
      grants = {grants[8:0], s_ar};
      if (s_ar) begin p_ard = p_ard + 5'd1; p_ares = p_ares + 32'd1; end
      if (s_lr) begin p_lrd = p_lrd + 5'd1; p_ldat = p_ldat + 32'd1; end
      if (i == 4) chk("starve.flag_on_forced", 32'(starve_flag), 32'd1);
      if (i == 5) chk("starve.flag_after", 32'(starve_flag), 32'd0);
    end
    chk("starve.grant_pattern", 32'(grants), 32'(10'b0000100001));

    // Build up three refusals, then reset between a transfer and its write.
    for (int i = 0; i < 3; i++)
      step($sformatf("pre_rst%0d", i), 1'b1, 5'd9, 32'hC0, 1'b0, 32'h0, 1'b1, 5'd11, 32'hD0 + i);
    chk("midrst.we_before", 32'(wb_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.we_dropped", 32'(wb_we), 32'd0);
    chk("midrst.alu_ready", 32'(alu_ready), 32'd0);
    chk("midrst.ld_ready", 32'(ld_ready), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs("midrst");
    rst_n = 1'b1;
    grants = '0;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("post_rst%0d", i), 1'b1, 5'd9, 32'hC0, 1'b0, 32'h0, 1'b1, 5'd11, 32'hE0 + i);
      grants = {grants[8:0], s_ar};
    end
    chk("post_rst.counter_cleared", 32'(grants[4:0]), 32'(5'b00001));

    // Randomized traffic; producers hold payload until accepted.
    p_av = 1'b0; p_lv = 1'b0; p_alink = 1'b0; p_apc = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p_av) begin
        p_av = ($urandom_range(0, 9) < 6);
        p_ard = 5'($urandom_range(0, 31)); p_ares = $urandom;
        p_alink = $urandom_range(0, 3) == 0; p_apc = $urandom;
      end
      if (!p_lv) begin
        p_lv = ($urandom_range(0, 9) < 6);
        p_lrd = 5'($urandom_range(0, 31)); p_ldat = $urandom;
      end
      step("rand", p_av, p_ard, p_ares, p_alink, p_apc, p_lv, p_lrd, p_ldat);
      if (g_alu) p_av = 1'b0;
      if (g_ld)  p_lv = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
